// File: rtl/axi_master_txn_engine_if.sv
// AXI4 master-side bus bundle for the transaction engine: AW/W/B/AR/R channels
// plus the sideband fields the engine ties off.
interface axi_master_txn_engine_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    localparam int STRB_W = DATA_W / 8;

    logic [ID_W-1:0]   AWID;
    logic [ADDR_W-1:0] AWADDR;
    logic [7:0]        AWLEN;
    logic [2:0]        AWSIZE;
    logic [1:0]        AWBURST;
    logic              AWLOCK;
    logic [3:0]        AWCACHE;
    logic [2:0]        AWPROT;
    logic [3:0]        AWQOS;
    logic [3:0]        AWREGION;
    logic              AWUSER;
    logic              AWVALID;
    logic              AWREADY;

    logic [DATA_W-1:0] WDATA;
    logic [STRB_W-1:0] WSTRB;
    logic              WLAST;
    logic              WUSER;
    logic              WVALID;
    logic              WREADY;

    logic [ID_W-1:0]   BID;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;

    logic [ID_W-1:0]   ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [7:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic              ARLOCK;
    logic [3:0]        ARCACHE;
    logic [2:0]        ARPROT;
    logic [3:0]        ARQOS;
    logic [3:0]        ARREGION;
    logic              ARUSER;
    logic              ARVALID;
    logic              ARREADY;

    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT,
               AWQOS, AWREGION, AWUSER, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WUSER, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT,
               ARQOS, ARREGION, ARUSER, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT,
               AWQOS, AWREGION, AWUSER, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WUSER, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT,
               ARQOS, ARREGION, ARUSER, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/axi_master_txn_engine.sv
// AXI initiator: turns one write or read command into a single INCR burst,
// with independent write and read engines, one outstanding burst each.
module axi_master_txn_engine #(
    parameter int         ADDR_W   = 32,
    parameter int         DATA_W   = 32,
    parameter int         ID_W     = 4,
    parameter logic [2:0] SIZE_ENC = 3'b010
) (
    input  logic                ACLK,
    input  logic                ARESET,

    input  logic                wr_cmd_valid,
    output logic                wr_cmd_ready,
    input  logic [ADDR_W-1:0]   wr_cmd_addr,
    input  logic [ID_W-1:0]     wr_cmd_id,
    input  logic [3:0]          wr_cmd_len,
    input  logic                wr_dat_valid,
    output logic                wr_dat_ready,
    input  logic [DATA_W-1:0]   wr_dat_data,
    input  logic [DATA_W/8-1:0] wr_dat_strb,
    output logic                wr_done,
    output logic [1:0]          wr_resp,
    output logic                wr_err,

    input  logic                rd_cmd_valid,
    output logic                rd_cmd_ready,
    input  logic [ADDR_W-1:0]   rd_cmd_addr,
    input  logic [ID_W-1:0]     rd_cmd_id,
    input  logic [3:0]          rd_cmd_len,
    input  logic                rd_ready,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic [1:0]          rd_resp,
    output logic                rd_last,
    output logic                rd_done,
    output logic                rd_err,

    axi_master_txn_engine_if.master m
);

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

    wstate_t           r_wstate;
    logic              r_wr_cmd_ready;
    logic              r_awvalid;
    logic [ADDR_W-1:0] r_awaddr;
    logic [ID_W-1:0]   r_awid;
    logic [3:0]        r_awlen;
    logic [3:0]        r_wcnt;
    logic              r_bready;
    logic              r_wr_done;
    logic [1:0]        r_wr_resp;
    logic              r_wr_err;

    rstate_t           r_rstate;
    logic              r_rd_cmd_ready;
    logic              r_arvalid;
    logic [ADDR_W-1:0] r_araddr;
    logic [ID_W-1:0]   r_arid;
    logic [3:0]        r_arlen;
    logic [3:0]        r_rcnt;
    logic              r_rerr_acc;
    logic              r_rd_done;
    logic              r_rd_err;

    logic w_in_wdata;
    logic w_w_hs;
    logic w_in_rdata;
    logic w_r_hs;
    logic w_r_last_beat;
    logic w_r_beat_err;

    // Data beats are gated by state so nothing leaks onto W before the AW handshake.
    assign w_in_wdata    = (r_wstate == W_DATA);
    assign w_w_hs        = w_in_wdata & wr_dat_valid & m.WREADY;
    assign w_in_rdata    = (r_rstate == R_DATA);
    assign w_r_hs        = w_in_rdata & m.RVALID & rd_ready;
    assign w_r_last_beat = (r_rcnt == r_arlen);
    assign w_r_beat_err  = (m.RID != r_arid) | (m.RLAST != w_r_last_beat);

    assign wr_cmd_ready = r_wr_cmd_ready;
    assign wr_dat_ready = w_in_wdata & m.WREADY;
    assign wr_done      = r_wr_done;
    assign wr_resp      = r_wr_resp;
    assign wr_err       = r_wr_err;

    assign rd_cmd_ready = r_rd_cmd_ready;
    assign rd_valid     = w_in_rdata & m.RVALID;
    assign rd_data      = w_in_rdata ? m.RDATA : {DATA_W{1'b0}};
    assign rd_resp      = w_in_rdata ? m.RRESP : 2'b00;
    assign rd_last      = w_in_rdata & m.RLAST;
    assign rd_done      = r_rd_done;
    assign rd_err       = r_rd_err;

    assign m.AWID     = r_awid;
    assign m.AWADDR   = r_awaddr;
    assign m.AWLEN    = {4'b0000, r_awlen};
    assign m.AWSIZE   = SIZE_ENC;
    assign m.AWBURST  = 2'b01;
    assign m.AWLOCK   = 1'b0;
    assign m.AWCACHE  = 4'b0000;
    assign m.AWPROT   = 3'b000;
    assign m.AWQOS    = 4'b0000;
    assign m.AWREGION = 4'b0000;
    assign m.AWUSER   = 1'b0;
    assign m.AWVALID  = r_awvalid;
    assign m.WDATA    = w_in_wdata ? wr_dat_data : {DATA_W{1'b0}};
    assign m.WSTRB    = w_in_wdata ? wr_dat_strb : {(DATA_W/8){1'b0}};
    assign m.WLAST    = w_in_wdata & (r_wcnt == r_awlen);
    assign m.WUSER    = 1'b0;
    assign m.WVALID   = w_in_wdata & wr_dat_valid;
    assign m.BREADY   = r_bready;

    assign m.ARID     = r_arid;
    assign m.ARADDR   = r_araddr;
    assign m.ARLEN    = {4'b0000, r_arlen};
    assign m.ARSIZE   = SIZE_ENC;
    assign m.ARBURST  = 2'b01;
    assign m.ARLOCK   = 1'b0;
    assign m.ARCACHE  = 4'b0000;
    assign m.ARPROT   = 3'b000;
    assign m.ARQOS    = 4'b0000;
    assign m.ARREGION = 4'b0000;
    assign m.ARUSER   = 1'b0;
    assign m.ARVALID  = r_arvalid;
    assign m.RREADY   = w_in_rdata & rd_ready;

    // Write engine: command capture, AW issue, beat counting, B response capture.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wstate       <= W_IDLE;
            r_wr_cmd_ready <= 1'b1;
            r_awvalid      <= 1'b0;
            r_awaddr       <= {ADDR_W{1'b0}};
            r_awid         <= {ID_W{1'b0}};
            r_awlen        <= 4'd0;
            r_wcnt         <= 4'd0;
            r_bready       <= 1'b0;
            r_wr_done      <= 1'b0;
            r_wr_resp      <= 2'b00;
            r_wr_err       <= 1'b0;
        end else begin
            r_wr_done <= 1'b0;
            r_wr_err  <= 1'b0;
            case (r_wstate)
                W_IDLE: begin
                    if (wr_cmd_valid) begin
                        r_awaddr       <= wr_cmd_addr;
                        r_awid         <= wr_cmd_id;
                        r_awlen        <= wr_cmd_len;
                        r_wcnt         <= 4'd0;
                        r_awvalid      <= 1'b1;
                        r_wr_cmd_ready <= 1'b0;
                        r_wstate       <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    if (m.AWREADY) begin
                        r_awvalid <= 1'b0;
                        r_wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        if (r_wcnt == r_awlen) begin
                            r_bready <= 1'b1;
                            r_wstate <= W_RESP;
                        end else begin
                            r_wcnt <= r_wcnt + 4'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (m.BVALID) begin
                        r_bready       <= 1'b0;
                        r_wr_done      <= 1'b1;
                        r_wr_resp      <= m.BRESP;
                        r_wr_err       <= (m.BID != r_awid);
                        r_wr_cmd_ready <= 1'b1;
                        r_wstate       <= W_IDLE;
                    end
                end
                default: begin
                    r_wstate       <= W_IDLE;
                    r_wr_cmd_ready <= 1'b1;
                    r_awvalid      <= 1'b0;
                    r_bready       <= 1'b0;
                end
            endcase
        end
    end

    // Read engine: AR issue, beat counting and sticky per-burst error tracking.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rstate       <= R_IDLE;
            r_rd_cmd_ready <= 1'b1;
            r_arvalid      <= 1'b0;
            r_araddr       <= {ADDR_W{1'b0}};
            r_arid         <= {ID_W{1'b0}};
            r_arlen        <= 4'd0;
            r_rcnt         <= 4'd0;
            r_rerr_acc     <= 1'b0;
            r_rd_done      <= 1'b0;
            r_rd_err       <= 1'b0;
        end else begin
            r_rd_done <= 1'b0;
            r_rd_err  <= 1'b0;
            case (r_rstate)
                R_IDLE: begin
                    if (rd_cmd_valid) begin
                        r_araddr       <= rd_cmd_addr;
                        r_arid         <= rd_cmd_id;
                        r_arlen        <= rd_cmd_len;
                        r_rcnt         <= 4'd0;
                        r_rerr_acc     <= 1'b0;
                        r_arvalid      <= 1'b1;
                        r_rd_cmd_ready <= 1'b0;
                        r_rstate       <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (m.ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    // Termination follows the local count, so a missing RLAST cannot hang the engine.
                    if (w_r_hs) begin
                        if (w_r_last_beat) begin
                            r_rd_done      <= 1'b1;
                            r_rd_err       <= r_rerr_acc | w_r_beat_err;
                            r_rd_cmd_ready <= 1'b1;
                            r_rstate       <= R_IDLE;
                        end else begin
                            r_rcnt     <= r_rcnt + 4'd1;
                            r_rerr_acc <= r_rerr_acc | w_r_beat_err;
                        end
                    end
                end
                default: begin
                    r_rstate       <= R_IDLE;
                    r_rd_cmd_ready <= 1'b1;
                    r_arvalid      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_master_txn_engine.sv
// Directed bench: table of write/read bursts against a scripted slave,
// plus stall, concurrency and mid-burst reset sequences.
module tb_axi_master_txn_engine;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [3:0]  len;
        logic [1:0]  bresp;
        logic [3:0]  bid;
        int          stall;
        logic        exp_err;
    } wvec_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [3:0]  len;
        int          bad_rid_beat;
        int          rlast_beat;
        logic        gaps;
        logic        exp_err;
    } rvec_t;

    logic        ACLK;
    logic        ARESET;
    logic        wr_cmd_valid, wr_cmd_ready;
    logic [31:0] wr_cmd_addr;
    logic [3:0]  wr_cmd_id, wr_cmd_len;
    logic        wr_dat_valid, wr_dat_ready;
    logic [31:0] wr_dat_data;
    logic [3:0]  wr_dat_strb;
    logic        wr_done;
    logic [1:0]  wr_resp;
    logic        wr_err;
    logic        rd_cmd_valid, rd_cmd_ready;
    logic [31:0] rd_cmd_addr;
    logic [3:0]  rd_cmd_id, rd_cmd_len;
    logic        rd_ready, rd_valid;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        rd_last, rd_done, rd_err;

    int n_checks = 0;
    int n_errors = 0;

    axi_master_txn_engine_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) bus ();

    axi_master_txn_engine #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .SIZE_ENC(3'b010)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
        .wr_cmd_addr(wr_cmd_addr), .wr_cmd_id(wr_cmd_id), .wr_cmd_len(wr_cmd_len),
        .wr_dat_valid(wr_dat_valid), .wr_dat_ready(wr_dat_ready),
        .wr_dat_data(wr_dat_data), .wr_dat_strb(wr_dat_strb),
        .wr_done(wr_done), .wr_resp(wr_resp), .wr_err(wr_err),
        .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
        .rd_cmd_addr(rd_cmd_addr), .rd_cmd_id(rd_cmd_id), .rd_cmd_len(rd_cmd_len),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_resp(rd_resp), .rd_last(rd_last), .rd_done(rd_done), .rd_err(rd_err),
        .m(bus)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_awvalid"}, 64'(bus.AWVALID), 64'd0);
        chk({tag, "_wvalid"},  64'(bus.WVALID),  64'd0);
        chk({tag, "_bready"},  64'(bus.BREADY),  64'd0);
        chk({tag, "_arvalid"}, 64'(bus.ARVALID), 64'd0);
        chk({tag, "_rready"},  64'(bus.RREADY),  64'd0);
        chk({tag, "_rd_valid"}, 64'(rd_valid),   64'd0);
        chk({tag, "_wr_done"}, 64'(wr_done),     64'd0);
        chk({tag, "_rd_done"}, 64'(rd_done),     64'd0);
        chk({tag, "_awaddr"},  64'(bus.AWADDR),  64'd0);
        chk({tag, "_araddr"},  64'(bus.ARADDR),  64'd0);
        chk({tag, "_awburst"}, 64'(bus.AWBURST), 64'd1);
        chk({tag, "_arsize"},  64'(bus.ARSIZE),  64'd2);
    endtask

    // abort_at >= 0 pulses ARESET before that beat instead of finishing the burst.
    task automatic do_write(input wvec_t v, input int abort_at);
        int len_i;
        len_i = int'(v.len);
        @(negedge ACLK);
        wr_cmd_valid = 1'b1; wr_cmd_addr = v.addr; wr_cmd_id = v.id; wr_cmd_len = v.len;
        #1 chk("wr_cmd_ready", 64'(wr_cmd_ready), 64'd1);
        @(negedge ACLK);
        wr_cmd_valid = 1'b0; wr_dat_valid = 1'b1; wr_dat_data = 32'h0000_00A0; wr_dat_strb = 4'hF;
        bus.AWREADY = 1'b0;
        for (int s = 0; s < v.stall; s++) begin
            #1;
            chk("aw_stall_valid", 64'(bus.AWVALID), 64'd1);
            chk("aw_stall_addr",  64'(bus.AWADDR),  64'(v.addr));
            chk("aw_stall_nowv",  64'(bus.WVALID),  64'd0);
            @(negedge ACLK);
        end
        bus.AWREADY = 1'b1;
        #1;
        chk("awvalid", 64'(bus.AWVALID), 64'd1);
        chk("awaddr",  64'(bus.AWADDR),  64'(v.addr));
        chk("awid",    64'(bus.AWID),    64'(v.id));
        chk("awlen",   64'(bus.AWLEN),   64'(v.len));
        chk("aw_nowv", 64'(bus.WVALID),  64'd0);
        @(negedge ACLK);
        bus.AWREADY = 1'b0; bus.WREADY = 1'b1;
        for (int b = 0; b <= len_i; b++) begin
            if (b == abort_at) begin
                ARESET = 1'b1;
                @(negedge ACLK);
                ARESET = 1'b0;
                #1;
                chk_idle("rst_mid");
                chk("rst_wr_dat_ready", 64'(wr_dat_ready), 64'd0);
                chk("rst_wr_cmd_ready", 64'(wr_cmd_ready), 64'd1);
                chk("rst_rd_cmd_ready", 64'(rd_cmd_ready), 64'd1);
                @(negedge ACLK);
                #1 chk("rst_no_done", 64'(wr_done), 64'd0);
                wr_dat_valid = 1'b0; bus.WREADY = 1'b0;
                return;
            end
            wr_dat_data = 32'h0000_00A0 + 32'(b);
            #1;
            chk("wvalid",       64'(bus.WVALID),  64'd1);
            chk("wdata",        64'(bus.WDATA),   64'(32'h0000_00A0 + 32'(b)));
            chk("wlast",        64'(bus.WLAST),   64'(b == len_i));
            chk("wr_dat_ready", 64'(wr_dat_ready), 64'd1);
            @(negedge ACLK);
        end
        wr_dat_valid = 1'b0; bus.WREADY = 1'b0;
        #1;
        chk("bready",       64'(bus.BREADY), 64'd1);
        chk("wr_done_early", 64'(wr_done),   64'd0);
        bus.BVALID = 1'b1; bus.BID = v.bid; bus.BRESP = v.bresp;
        @(negedge ACLK);
        bus.BVALID = 1'b0;
        #1;
        chk("wr_done",   64'(wr_done),     64'd1);
        chk("wr_resp",   64'(wr_resp),     64'(v.bresp));
        chk("wr_err",    64'(wr_err),      64'(v.exp_err));
        chk("bready_lo", 64'(bus.BREADY),  64'd0);
        @(negedge ACLK);
        #1 chk("wr_done_pulse", 64'(wr_done), 64'd0);
    endtask

    task automatic do_read(input rvec_t v);
        int   len_i;
        int   beat;
        logic vld;
        logic rdy;
        len_i = int'(v.len);
        @(negedge ACLK);
        rd_cmd_valid = 1'b1; rd_cmd_addr = v.addr; rd_cmd_id = v.id; rd_cmd_len = v.len;
        #1 chk("rd_cmd_ready", 64'(rd_cmd_ready), 64'd1);
        @(negedge ACLK);
        rd_cmd_valid = 1'b0; bus.ARREADY = 1'b1;
        #1;
        chk("arvalid", 64'(bus.ARVALID), 64'd1);
        chk("araddr",  64'(bus.ARADDR),  64'(v.addr));
        chk("arid",    64'(bus.ARID),    64'(v.id));
        chk("arlen",   64'(bus.ARLEN),   64'(v.len));
        @(negedge ACLK);
        bus.ARREADY = 1'b0;
        beat = 0; vld = 1'b0;
        for (int c = 0; c < 200 && beat <= len_i; c++) begin
            if (c > 0) @(negedge ACLK);
            if (!vld) vld = v.gaps ? ((c % 3) != 2) : 1'b1;
            rdy = v.gaps ? ((c % 2) == 0) : 1'b1;
            bus.RVALID = vld;
            bus.RDATA  = 32'hDEAD_BEEF + 32'(beat);
            bus.RID    = (beat == v.bad_rid_beat) ? 4'd6 : v.id;
            bus.RLAST  = (beat == v.rlast_beat);
            bus.RRESP  = 2'b00;
            rd_ready   = rdy;
            #1;
            chk("rd_valid",     64'(rd_valid),   64'(vld));
            chk("rready",       64'(bus.RREADY), 64'(rdy));
            chk("rd_done_mid",  64'(rd_done),    64'd0);
            if (c == 0) chk("arvalid_lo", 64'(bus.ARVALID), 64'd0);
            if (vld && rdy) begin
                chk("rd_data", 64'(rd_data), 64'(32'hDEAD_BEEF + 32'(beat)));
                chk("rd_last", 64'(rd_last), 64'(beat == v.rlast_beat));
                beat++;
                vld = 1'b0;
            end
        end
        chk("rd_beats", 64'(beat), 64'(len_i + 1));
        @(negedge ACLK);
        bus.RVALID = 1'b0; rd_ready = 1'b0; bus.RLAST = 1'b0;
        #1;
        chk("rd_done",      64'(rd_done),      64'd1);
        chk("rd_err",       64'(rd_err),       64'(v.exp_err));
        chk("rd_cmd_ready_back", 64'(rd_cmd_ready), 64'd1);
        @(negedge ACLK);
        #1 chk("rd_done_pulse", 64'(rd_done), 64'd0);
    endtask

    wvec_t wv[3];
    rvec_t rv[4];

    initial begin
        wv[0] = '{addr: 32'h1000_0040, id: 4'd3, len: 4'd3,  bresp: 2'b00, bid: 4'd3, stall: 0, exp_err: 1'b0};
        wv[1] = '{addr: 32'h1000_0100, id: 4'd7, len: 4'd0,  bresp: 2'b10, bid: 4'd7, stall: 5, exp_err: 1'b0};
        wv[2] = '{addr: 32'h1000_0200, id: 4'd1, len: 4'd15, bresp: 2'b00, bid: 4'd2, stall: 1, exp_err: 1'b1};
        rv[0] = '{addr: 32'h2000_0000, id: 4'd5, len: 4'd0,  bad_rid_beat: 99, rlast_beat: 0,  gaps: 1'b0, exp_err: 1'b0};
        rv[1] = '{addr: 32'h2000_1000, id: 4'd2, len: 4'd15, bad_rid_beat: 99, rlast_beat: 15, gaps: 1'b1, exp_err: 1'b0};
        rv[2] = '{addr: 32'h2000_2000, id: 4'd4, len: 4'd3,  bad_rid_beat: 99, rlast_beat: 1,  gaps: 1'b0, exp_err: 1'b1};
        rv[3] = '{addr: 32'h2000_3000, id: 4'd4, len: 4'd3,  bad_rid_beat: 2,  rlast_beat: 3,  gaps: 1'b0, exp_err: 1'b1};

        ARESET = 1'b1;
        wr_cmd_valid = 1'b0; wr_cmd_addr = 32'd0; wr_cmd_id = 4'd0; wr_cmd_len = 4'd0;
        wr_dat_valid = 1'b0; wr_dat_data = 32'd0; wr_dat_strb = 4'd0;
        rd_cmd_valid = 1'b0; rd_cmd_addr = 32'd0; rd_cmd_id = 4'd0; rd_cmd_len = 4'd0;
        rd_ready = 1'b0;
        bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.ARREADY = 1'b0;
        bus.BID = 4'd0; bus.BRESP = 2'b00; bus.BVALID = 1'b0;
        bus.RID = 4'd0; bus.RDATA = 32'd0; bus.RRESP = 2'b00; bus.RLAST = 1'b0; bus.RVALID = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        #1;
        chk_idle("reset");
        chk("reset_awsize",  64'(bus.AWSIZE),  64'd2);
        chk("reset_arburst", 64'(bus.ARBURST), 64'd1);
        chk("reset_awid",    64'(bus.AWID),    64'd0);
        ARESET = 1'b0;

        for (int i = 0; i < 3; i++) do_write(wv[i], -1);
        for (int i = 0; i < 4; i++) do_read(rv[i]);

        // Both engines issue in the same cycle, then a reset abandons them.
        @(negedge ACLK);
        wr_cmd_valid = 1'b1; wr_cmd_addr = 32'h3000_0000; wr_cmd_id = 4'd9; wr_cmd_len = 4'd2;
        rd_cmd_valid = 1'b1; rd_cmd_addr = 32'h3000_0800; rd_cmd_id = 4'd10; rd_cmd_len = 4'd2;
        @(negedge ACLK);
        wr_cmd_valid = 1'b0; rd_cmd_valid = 1'b0;
        #1;
        chk("conc_awvalid", 64'(bus.AWVALID), 64'd1);
        chk("conc_arvalid", 64'(bus.ARVALID), 64'd1);
        chk("conc_araddr",  64'(bus.ARADDR),  64'h3000_0800);
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        #1 chk_idle("conc_rst");

        // Reset after beat 1 of a len=7 write, then a normal write.
        do_write('{addr: 32'h1000_0400, id: 4'd2, len: 4'd7, bresp: 2'b00, bid: 4'd2, stall: 0, exp_err: 1'b0}, 2);
        do_write('{addr: 32'h1000_0500, id: 4'd6, len: 4'd1, bresp: 2'b01, bid: 4'd6, stall: 0, exp_err: 1'b0}, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_master_txn_engine.md
Name: axi_master_txn_engine

Overview:
- RTL AXI initiator that drives the master side of an AXI slave port (AW/W/AR out, B/R in).
- Converts single-command requests into one INCR write burst or one INCR read burst.
- Independent write and read engines; at most one outstanding transaction per direction.
- Used as a synthesizable traffic source against any slave port of the 4-master/7-slave interconnect.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- ID_W, 4, transaction ID width
- SIZE_ENC, 3'b010, fixed AxSIZE (4 bytes per beat)

Ports:
- ACLK  input  1  clock; all logic on the rising edge
- ARESET  input  1  synchronous reset, active high
- wr_cmd_valid/wr_cmd_ready  in/out  1/1  write command handshake
- wr_cmd_addr/wr_cmd_id/wr_cmd_len  in  ADDR_W/ID_W/4  write start address, ID, beats-1
- wr_dat_valid/wr_dat_ready  in/out  1/1  write data stream handshake
- wr_dat_data/wr_dat_strb  in  DATA_W/DATA_W/8  beat payload
- wr_done/wr_resp  out  1/2  one-cycle pulse with captured BRESP
- wr_err  out  1  pulse with wr_done when BID does not equal the issued ID
- rd_cmd_valid/rd_cmd_ready  in/out  1/1  read command handshake
- rd_cmd_addr/rd_cmd_id/rd_cmd_len  in  ADDR_W/ID_W/4  read command fields
- rd_ready  in  1  consumer backpressure
- rd_valid/rd_data/rd_resp/rd_last  out  1/DATA_W/2/1  returned beats
- rd_done/rd_err  out  1/1  end pulse; error on RID mismatch or RLAST misplacement
- M_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID, M_AWREADY  out/in  write address channel
- M_WDATA/WSTRB/WLAST/WVALID, M_WREADY  out/in  write data channel
- M_BID/BRESP/BVALID, M_BREADY  in/out  write response channel
- M_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID, M_ARREADY  out/in  read address channel
- M_RID/RDATA/RRESP/RLAST/RVALID, M_RREADY  in/out  read data channel
- M_AxLOCK/CACHE/PROT/QOS/REGION/USER, M_WUSER  out  constant 0 for both AW and AR

Behaviour:
- Reset (ARESET=1 at a rising edge):
  - Both FSMs go to IDLE.
  - All VALID outputs, M_BREADY, M_RREADY, done/err pulses and rd_valid are 0.
  - Address, data and ID outputs are 0.
  - AxBURST=2'b01 and AxSIZE=SIZE_ENC are constant, including during reset.
  - A reset during a burst abandons it immediately; no done pulse is generated.
- Write FSM, W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: wr_cmd_ready=1. When wr_cmd_valid=1, register addr/id/len, clear beat counter, and move to W_ADDR on the next cycle.
  - W_ADDR: AWVALID=1 with stable fields. Move to W_DATA on AWVALID&AWREADY.
  - W_DATA: WVALID=wr_dat_valid, wr_dat_ready=WREADY, WDATA/WSTRB pass through combinationally. WLAST=1 exactly when beat counter equals len. The counter increments on each W handshake. On the last handshake, move to W_RESP.
  - W_RESP: BREADY=1. On BVALID, pulse wr_done for one cycle with wr_resp=BRESP, set wr_err=(BID!=id), and return to W_IDLE.
  - W_DATA beats are never issued before the AW handshake.
- Read FSM, R_IDLE -> R_ADDR -> R_DATA -> R_IDLE:
  - R_IDLE: rd_cmd_ready=1; accepts a command like the write side.
  - R_ADDR: ARVALID=1 until ARREADY.
  - R_DATA: RREADY=rd_ready. rd_valid=RVALID, and rd_data/rd_resp/rd_last pass through.
  - The beat counter increments on each R handshake.
  - rd_err is sticky for the burst. It is set on any beat with RID!=id, or with RLAST asserted on a beat other than beat len.
  - After the handshake on beat len, rd_done pulses one cycle with rd_err, and the FSM returns to R_IDLE. If RLAST is missing on that beat, the engine still terminates and flags the error.
- VALID/payload stability: once AWVALID, ARVALID or WVALID is raised, it holds with constant payload until its READY, per AXI.
- Concurrency: the write and read engines are fully independent. Simultaneous AW and AR issue is permitted in the same cycle.
- Counters: the beat counter is 4 bits and never wraps. len=15 gives 16 beats, with WLAST on count 15.
- len=0: single beat with WLAST=1 on the first beat.

Test Plan:
- Write cmd addr=0x1000_0040, id=3, len=3, data 0xA0..A3, slave ready always -> AW then 4 W beats with WLAST only on 0xA3, BRESP=OKAY, wr_done=1, wr_err=0.
- Read cmd addr=0x2000_0000, id=5, len=0; slave returns RID=5, RLAST=1, data 0xDEAD_BEEF -> one rd_valid beat, rd_last=1, rd_done=1, rd_err=0.
- Read len=15 with rd_ready toggling every other cycle and RVALID gaps -> exactly 16 beats delivered in order, no beat lost or duplicated.
- Slave holds AWREADY=0 for 5 cycles -> AWVALID and AWADDR stay constant for 5 cycles; no WVALID before the AW handshake.
- Read len=3 with slave asserting RLAST on beat 1, or RID=6 on beat 2 -> rd_err=1 with rd_done after beat 3.
- Assert ARESET mid write burst (after beat 1 of len=7) -> next cycle all VALIDs are 0, both FSMs idle, no wr_done; a new command is then accepted normally.
